// File: rtl/palette_lut_dbuf.sv
// palette_lut_dbuf: double-buffered palette lookup for a VGA pixel stream.
// Reads use the active bank. Writes go to the shadow bank. A swap request is
// held off until the read pipeline has drained.
// Optional feature: define PALETTE_FADE_EN to add an 8-bit fade input and a
// third pipeline stage that scales every channel by (fade+1)/256.
module palette_lut_dbuf #(
    parameter int IDX_W   = 8,
    parameter int COLOR_W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 pix_valid,
    input  logic [IDX_W-1:0]     pix_idx,
    input  logic                 pix_blank,
`ifdef PALETTE_FADE_EN
    input  logic [7:0]           fade,
`endif
    output logic                 out_valid,
    output logic [COLOR_W-1:0]   VGA_R,
    output logic [COLOR_W-1:0]   VGA_G,
    output logic [COLOR_W-1:0]   VGA_B,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic [IDX_W-1:0]     wr_addr,
    input  logic [3*COLOR_W-1:0] wr_data,
    input  logic                 swap_req,
    output logic                 swap_done,
    output logic                 active_bank
);

    localparam int DEPTH = 2**IDX_W;
    localparam int ENT_W = 3*COLOR_W;

    typedef enum logic [1:0] {INIT, IDLE, SWAP_PEND} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_cnt;
    logic               r_pend, w_pend_nxt;
    logic               r_active;
    logic               r_swap_done;
    logic               w_swap_now;
    logic               w_init_we;
    logic               w_wr_ready;
    logic               w_wr_fire;
    logic               w_pipe_busy;

    logic [ENT_W-1:0]   r_bank0 [DEPTH];
    logic [ENT_W-1:0]   r_bank1 [DEPTH];

    logic               r_s1_vld, r_s1_blank;
    logic [IDX_W-1:0]   r_s1_idx;
    logic               r_s2_vld, r_s2_blank;
    logic [ENT_W-1:0]   r_s2_data;

    logic               w_out_vld, w_out_blank;
    logic [ENT_W-1:0]   w_out_rgb;

`ifdef PALETTE_FADE_EN
    logic [7:0]         r_s1_fade, r_s2_fade;
    logic               r_s3_vld, r_s3_blank;
    logic [ENT_W-1:0]   r_s3_rgb;

    function automatic logic [COLOR_W-1:0] fade_ch(input logic [COLOR_W-1:0] c,
                                                   input logic [7:0] f);
        logic [COLOR_W+8:0] p;
        p = (COLOR_W+9)'(c) * (COLOR_W+9)'({1'b0, f} + 9'd1);
        return p[COLOR_W+7:8];
    endfunction

    assign w_pipe_busy = pix_valid | r_s1_vld | r_s2_vld | r_s3_vld;
    assign w_out_vld   = r_s3_vld;
    assign w_out_blank = r_s3_blank;
    assign w_out_rgb   = r_s3_rgb;
`else
    assign w_pipe_busy = pix_valid | r_s1_vld | r_s2_vld;
    assign w_out_vld   = r_s2_vld;
    assign w_out_blank = r_s2_blank;
    assign w_out_rgb   = r_s2_data;
`endif

    assign w_wr_fire   = wr_valid && w_wr_ready;
    assign wr_ready    = w_wr_ready;
    assign swap_done   = r_swap_done;
    assign active_bank = r_active;

    // Next-state logic: clear sweep, write/swap acceptance, drain wait.
    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_wr_ready  = 1'b0;
        w_init_we   = 1'b0;
        w_swap_now  = 1'b0;
        case (r_state)
            INIT: begin
                w_init_we = 1'b1;
                if (swap_req) w_pend_nxt = 1'b1;
                if (&r_cnt)   w_state_nxt = IDLE;
            end
            IDLE: begin
                w_wr_ready = 1'b1;
                if (swap_req || r_pend) begin
                    w_state_nxt = SWAP_PEND;
                    w_pend_nxt  = 1'b0;
                end
            end
            SWAP_PEND: begin
                // Swap only once nothing is in flight, so no pixel mixes banks.
                if (!w_pipe_busy) begin
                    w_swap_now  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = INIT;
        endcase
    end

    // Control registers: state, clear counter, pending swap, bank select.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= INIT;
            r_cnt       <= '0;
            r_pend      <= 1'b0;
            r_active    <= 1'b0;
            r_swap_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pend      <= w_pend_nxt;
            r_swap_done <= w_swap_now;
            if (w_init_we) r_cnt <= r_cnt + 1'b1;
            if (w_swap_now) r_active <= ~r_active;
        end
    end

    // Bank 0 storage: cleared during INIT, written only while it is shadow.
    always_ff @(posedge Clk) begin
        if (w_init_we)
            r_bank0[r_cnt] <= '0;
        else if (w_wr_fire && r_active)
            r_bank0[wr_addr] <= wr_data;
    end

    // Bank 1 storage: cleared during INIT, written only while it is shadow.
    always_ff @(posedge Clk) begin
        if (w_init_we)
            r_bank1[r_cnt] <= '0;
        else if (w_wr_fire && !r_active)
            r_bank1[wr_addr] <= wr_data;
    end

    // Stage-2 data: synchronous read of the active bank.
    always_ff @(posedge Clk) begin
        r_s2_data <= r_active ? r_bank1[r_s1_idx] : r_bank0[r_s1_idx];
    end

    // Pipeline control: valid, blank and index travel with the pixel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1_vld   <= 1'b0;
            r_s1_blank <= 1'b0;
            r_s1_idx   <= '0;
            r_s2_vld   <= 1'b0;
            r_s2_blank <= 1'b0;
        end else begin
            r_s1_vld   <= pix_valid;
            r_s1_blank <= pix_blank;
            r_s1_idx   <= pix_idx;
            r_s2_vld   <= r_s1_vld;
            r_s2_blank <= r_s1_blank;
        end
    end

`ifdef PALETTE_FADE_EN
    // Fade stage: fade follows the pixel, then scales each channel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_s1_fade  <= '0;
            r_s2_fade  <= '0;
            r_s3_vld   <= 1'b0;
            r_s3_blank <= 1'b0;
            r_s3_rgb   <= '0;
        end else begin
            r_s1_fade  <= fade;
            r_s2_fade  <= r_s1_fade;
            r_s3_vld   <= r_s2_vld;
            r_s3_blank <= r_s2_blank;
            r_s3_rgb   <= {fade_ch(r_s2_data[3*COLOR_W-1:2*COLOR_W], r_s2_fade),
                           fade_ch(r_s2_data[2*COLOR_W-1:COLOR_W],   r_s2_fade),
                           fade_ch(r_s2_data[COLOR_W-1:0],           r_s2_fade)};
        end
    end
`endif

    // Output gating: black whenever there is no pixel or it is blanked.
    always_comb begin
        out_valid = w_out_vld;
        VGA_R     = '0;
        VGA_G     = '0;
        VGA_B     = '0;
        if (w_out_vld && !w_out_blank) begin
            VGA_R = w_out_rgb[3*COLOR_W-1:2*COLOR_W];
            VGA_G = w_out_rgb[2*COLOR_W-1:COLOR_W];
            VGA_B = w_out_rgb[COLOR_W-1:0];
        end
    end

endmodule

// File: tb/tb_palette_lut_dbuf.sv
// Testbench for palette_lut_dbuf: directed pixel/write/swap sequences with a
// queue-based scoreboard checked by an independent output monitor.
module tb_palette_lut_dbuf;

`ifdef PALETTE_FADE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        Clk = 1'b0;
    logic        Reset;
    logic        pix_valid, pix_blank;
    logic [7:0]  pix_idx;
    logic        out_valid;
    logic [7:0]  VGA_R, VGA_G, VGA_B;
    logic        wr_valid, wr_ready;
    logic [7:0]  wr_addr;
    logic [23:0] wr_data;
    logic        swap_req, swap_done, active_bank;
`ifdef PALETTE_FADE_EN
    logic [7:0]  fade;
`endif

    int          checks = 0;
    int          errors = 0;
    int          swap_pulses = 0;
    logic [23:0] exp_q[$];

    palette_lut_dbuf #(.IDX_W(8), .COLOR_W(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .pix_valid(pix_valid), .pix_idx(pix_idx), .pix_blank(pix_blank),
`ifdef PALETTE_FADE_EN
        .fade(fade),
`endif
        .out_valid(out_valid), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .swap_req(swap_req), .swap_done(swap_done), .active_bank(active_bank)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clk);
    endtask

    // Monitor: pops an expected colour for every pixel the DUT presents.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge Clk);
            if (!Reset) begin
                if (swap_done) swap_pulses++;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("pix_unexpected", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pix_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(e));
                    end
                end else begin
                    chk("rgb_idle_zero", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);
                end
            end
        end
    end

    // One pixel for one cycle; its expected colour goes onto the scoreboard.
    task automatic pix1(input logic [7:0] idx, input logic blank, input logic [23:0] e,
                        input logic sreq);
        pix_valid = 1'b1; pix_idx = idx; pix_blank = blank; swap_req = sreq;
        exp_q.push_back(blank ? 24'h000000 : e);
        tick();
        pix_valid = 1'b0; pix_blank = 1'b0; swap_req = 1'b0;
    endtask

    task automatic drain();
        repeat (LAT + 3) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [23:0] d, input logic sreq);
        wr_valid = 1'b1; wr_addr = a; wr_data = d; swap_req = sreq;
        chk("wr_ready_idle", 32'(wr_ready), 32'd1);
        tick();
        wr_valid = 1'b0; swap_req = 1'b0;
    endtask

    task automatic wait_swap(input string name);
        int n;
        n = 0;
        while (!swap_done && n < 20) begin tick(); n++; end
        chk(name, 32'(swap_done), 32'd1);
    endtask

    task automatic count_init(input string name);
        int n;
        n = 0;
        while (n < 400) begin
            tick(); n++;
            if (wr_ready) break;
        end
        chk(name, 32'(n), 32'd256);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int pulses0;
        Reset = 1'b1; pix_valid = 1'b0; pix_idx = '0; pix_blank = 1'b0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; swap_req = 1'b0;
`ifdef PALETTE_FADE_EN
        fade = 8'hFF;
`endif
        repeat (3) tick();
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_active_bank", 32'(active_bank), 32'd0);
        chk("rst_swap_done", 32'(swap_done), 32'd0);
        chk("rst_rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'd0);

        // Reset mid-sweep restarts clearing from entry 0.
        Reset = 1'b0;
        repeat (100) tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        count_init("init_cycles");

        // Cleared palette reads back black.
        pix1(8'h37, 1'b0, 24'h000000, 1'b0);
        drain();

        // Write shadow entry, swap, read it from the new active bank.
        wr(8'h05, 24'hFF8000, 1'b0);
        swap_req = 1'b1; tick(); swap_req = 1'b0;
        chk("wr_ready_swap_pend", 32'(wr_ready), 32'd0);
        wait_swap("swap1_done");
        tick();
        chk("active_after_swap1", 32'(active_bank), 32'd1);
        pix1(8'h05, 1'b0, 24'hFF8000, 1'b0);
        drain();

        // Shadow write without a swap leaves the visible colour untouched.
        wr(8'h05, 24'h123456, 1'b0);
        pix1(8'h05, 1'b0, 24'hFF8000, 1'b0);
        drain();

        // Write and swap in the same cycle; the write lands pre-swap shadow.
        wr(8'h10, 24'hABCDEF, 1'b1);
        wait_swap("swap2_done");
        tick();
        chk("active_after_swap2", 32'(active_bank), 32'd0);
        pix1(8'h05, 1'b0, 24'h123456, 1'b0);
        pix1(8'h10, 1'b0, 24'hABCDEF, 1'b0);
        drain();

        // Swap requested mid-burst: whole burst from old bank, single swap.
        pulses0 = swap_pulses;
        pix1(8'h05, 1'b0, 24'h123456, 1'b0);
        pix1(8'h10, 1'b0, 24'hABCDEF, 1'b1);
        pix1(8'h37, 1'b0, 24'h000000, 1'b1);
        pix1(8'h05, 1'b0, 24'h123456, 1'b0);
        n = 0;
        while (n < 20) begin
            tick(); n++;
            if (swap_done) break;
        end
        chk("swap_after_drain", 32'(n), 32'(LAT + 1));
        repeat (5) tick();
        chk("single_swap_pulse", 32'(swap_pulses - pulses0), 32'd1);
        chk("active_after_swap3", 32'(active_bank), 32'd1);
        pix1(8'h05, 1'b0, 24'hFF8000, 1'b0);
        pix1(8'h10, 1'b0, 24'h000000, 1'b0);
        drain();

        // Blanked pixel is valid but black.
        pix1(8'h05, 1'b1, 24'h000000, 1'b0);
        drain();

`ifdef PALETTE_FADE_EN
        fade = 8'h7F;
        pix1(8'h05, 1'b0, 24'h7F4000, 1'b0);
        fade = 8'hFF;
        drain();
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
